// File: rtl/reg_file_pkg.sv
// Shared defaults, state encoding and constants for the parametrised register file.
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Register 0 is hardwired to zero on both read ports and ignores writes.
  localparam int REG_ZERO = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/reg_file_bank.sv
// Storage array: one synchronous write port and two asynchronous read ports.
module reg_file_bank
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] d,
  input  logic [ADDR_W-1:0] dpra1,
  output logic [DATA_W-1:0] dpo1,
  input  logic [ADDR_W-1:0] dpra2,
  output logic [DATA_W-1:0] dpo2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[a] <= d;
    end
  end

  assign dpo1 = mem[dpra1];
  assign dpo2 = mem[dpra2];

endmodule

// File: rtl/reg_file_param.sv
// Two-read/one-write register file with post-reset hardware clear, READY
// handshake, dropped-write flag and optional same-cycle write bypass.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] A1,
  output logic [DATA_W-1:0] RD1,
  input  logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] RD2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              WE3,
  output logic              READY,
  output logic              WDROP
);

  localparam logic [ADDR_W-1:0] LAST_PTR  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic              ready;

  logic              bank_we;
  logic [ADDR_W-1:0] bank_a;
  logic [DATA_W-1:0] bank_d;
  logic [DATA_W-1:0] bank_q1;
  logic [DATA_W-1:0] bank_q2;

  // Clear walks every entry once; READY rises on the same edge that clears the last one.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_ptr == LAST_PTR) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        RUN: begin
          state <= RUN;
          ready <= 1'b1;
        end
        default: begin
          state   <= CLEAR;
          clr_ptr <= '0;
          ready   <= 1'b0;
        end
      endcase
    end
  end

  // The clear write owns the bank port while clearing; user writes only land in RUN.
  always_comb begin
    bank_we = 1'b0;
    bank_a  = clr_ptr;
    bank_d  = '0;
    if (!RESET) begin
      if (state == CLEAR) begin
        bank_we = 1'b1;
      end else if (WE3 && (A3 != ZERO_ADDR)) begin
        bank_we = 1'b1;
        bank_a  = A3;
        bank_d  = WD3;
      end
    end
  end

  reg_file_bank #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_bank (
    .clk  (CLK),
    .we   (bank_we),
    .a    (bank_a),
    .d    (bank_d),
    .dpra1(A1),
    .dpo1 (bank_q1),
    .dpra2(A2),
    .dpo2 (bank_q2)
  );

  function automatic logic [DATA_W-1:0] resolve_read(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              running,
    input logic              wr_en,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_data
  );
    logic [DATA_W-1:0] result;
    result = stored;
    if (addr == ZERO_ADDR || !running) begin
      result = '0;
    end else if (BYPASS && wr_en && (wr_addr == addr)) begin
      result = wr_data;
    end
    return result;
  endfunction

  assign RD1   = resolve_read(A1, bank_q1, state == RUN, WE3, A3, WD3);
  assign RD2   = resolve_read(A2, bank_q2, state == RUN, WE3, A3, WD3);
  assign READY = ready;
  assign WDROP = WE3 & ~ready;

endmodule
